// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async_fifo write port among NREQ producers,
// granting bursts of up to MAX_BURST words and never writing while full.
module async_fifo_wr_arbiter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      w_clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  input  logic                      full,
  output logic [NREQ-1:0]           gnt,
  output logic                      wr_rq,
  output logic [WIDTH-1:0]          wdata,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner_nxt;
  logic [OW-1:0]   last, last_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [OW-1:0]   winner;
  logic [OW-1:0]   idx;
  logic            found;
  logic [WIDTH-1:0] sel_data;
  logic            xfer;

  // State register; reset pointer to NREQ-1 so requester 0 is scanned first
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      cnt   <= '0;
      last  <= OW'(NREQ - 1);
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Round-robin search from last+1 upward, plus owner data mux
  always_comb begin
    winner   = last;
    found    = 1'b0;
    idx      = '0;
    sel_data = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = OW'((32'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner == OW'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state and zero-latency write-port outputs
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    gnt       = '0;
    wr_rq     = 1'b0;
    wdata     = '0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = winner;
          last_nxt  = winner;
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        xfer = req[owner] & ~full;
        if (!req[owner]) begin
          state_nxt = IDLE;
        end else if (xfer) begin
          gnt[owner] = 1'b1;
          wr_rq      = 1'b1;
          wdata      = sel_data;
          cnt_nxt    = cnt + 1'b1;
          if (cnt_nxt == CW'(MAX_BURST)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == BURST);

endmodule
